// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMulBusy,
    StMulDone
  } mul_state_e;

  // Operand mux selects driven on fw1/fw2.
  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_WB  = 2'b01;
  localparam logic [1:0] FW_EXM = 2'b10;

  function automatic logic reg_match(input logic wr_en, input logic [7:0] rd,
                                     input logic [7:0] rs);
    return wr_en && (rd != 8'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one ALU operand: picks EX/M, M/WB or regfile data.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_m_rd,
  input  logic                  ex_m_reg_write,
  input  logic [REG_ADDR_W-1:0] m_wb_rd,
  input  logic                  m_wb_reg_write,
  output logic [1:0]            fw_sel
);

  logic exm_hit;
  logic wb_hit;

  always_comb begin
    exm_hit = reg_match(ex_m_reg_write, 8'(ex_m_rd), 8'(id_ex_rs));
    wb_hit  = reg_match(m_wb_reg_write, 8'(m_wb_rd), 8'(id_ex_rs));
    // The younger producer in EX/M holds the newer value.
    if (exm_hit) begin
      fw_sel = FW_EXM;
    end else if (wb_hit) begin
      fw_sel = FW_WB;
    end else begin
      fw_sel = FW_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_LAT     = 3,
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_is_mul,
  input  logic [REG_ADDR_W-1:0] ex_m_rd,
  input  logic                  ex_m_reg_write,
  input  logic [REG_ADDR_W-1:0] m_wb_rd,
  input  logic                  m_wb_reg_write,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_m_en,
  output logic                  m_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_m_flush,
  output logic [1:0]            fw1,
  output logic [1:0]            fw2,
  output logic                  mul_start,
  output logic                  mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  localparam int unsigned MulCntW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [MulCntW-1:0] MulCntInit = (MUL_LAT > 2) ? MulCntW'(MUL_LAT - 3) : '0;
  localparam bit MulStalls = (MUL_LAT > 1);
  localparam bit MulHasBusy = (MUL_LAT > 2);
  localparam bit FlushExM = (FLUSH_DEPTH == 3);

  mul_state_e         state_q, state_d;
  logic [MulCntW-1:0] cnt_q, cnt_d;

  logic [1:0] fw1_raw;
  logic [1:0] fw2_raw;
  logic       load_use;
  logic       mul_stall;
  logic       unused_id_ex_reg_write;

  assign unused_id_ex_reg_write = id_ex_reg_write;

  hazard_fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .id_ex_rs      (id_ex_rs1),
    .ex_m_rd       (ex_m_rd),
    .ex_m_reg_write(ex_m_reg_write),
    .m_wb_rd       (m_wb_rd),
    .m_wb_reg_write(m_wb_reg_write),
    .fw_sel        (fw1_raw)
  );

  hazard_fwd_sel #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .id_ex_rs      (id_ex_rs2),
    .ex_m_rd       (ex_m_rd),
    .ex_m_reg_write(ex_m_reg_write),
    .m_wb_rd       (m_wb_rd),
    .m_wb_reg_write(m_wb_reg_write),
    .fw_sel        (fw2_raw)
  );

  assign fw1 = rst ? FW_RF : fw1_raw;
  assign fw2 = rst ? FW_RF : fw2_raw;

  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    mul_stall = (state_q == StMulBusy) || ((state_q == StRun) && id_ex_is_mul && MulStalls);
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_m_en     = 1'b1;
    m_wb_en     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_m_flush  = 1'b0;
    mul_start   = 1'b0;
    mul_busy    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (rst || !enable) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      ex_m_en  = 1'b0;
      m_wb_en  = 1'b0;
    end else if (branch_taken) begin
      // Any multiply still in ID/EX is younger than the branch and dies here.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_m_flush  = FlushExM;
      state_d     = StRun;
      cnt_d       = '0;
    end else if (mul_stall) begin
      mul_busy   = 1'b1;
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_m_flush = 1'b1;
      if (state_q == StRun) begin
        mul_start = 1'b1;
        state_d   = MulHasBusy ? StMulBusy : StMulDone;
        cnt_d     = MulCntInit;
      end else if (cnt_q == '0) begin
        state_d = StMulDone;
      end else begin
        cnt_d = cnt_q - MulCntW'(1);
      end
    end else begin
      if (state_q == StMulDone) begin
        state_d = StRun;
      end
      if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (enable) begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (branch_taken && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  // Counter width only matters when the perf counters are built in.
  if (CNT_W == 0) begin : g_no_perf_cnt
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall, flush and forwarding controller for the 5-stage RISC-V pipeline (IF, ID, EX, M, WB).
- Successor to the forwarding-only scheme. Adds:
  - load-use stall;
  - a multi-cycle multiply stall with a configurable latency;
  - taken-branch flush at a configurable resolve stage.
- Drives the enables and bubble-inserts of every pipeline register, and the ALU operand mux selects.

Parameters:
REG_ADDR_W, 5, register index width
MUL_LAT, 3, EX-stage multiply latency in cycles (>=1; 1 = no stall)
FLUSH_DEPTH, 3, number of younger stages squashed on taken branch (2 = resolved in EX, 3 = resolved in M)
CNT_W, 32, perf counter width (HAZARD_PERF_CNT_EN only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  global run; low freezes everything
id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
id_ex_rs1, id_ex_rs2, id_ex_rd  in  REG_ADDR_W  ID/EX register indices
id_ex_mem_read, id_ex_reg_write, id_ex_is_mul  in  1  ID/EX control
ex_m_rd  in  REG_ADDR_W; ex_m_reg_write  in  1
m_wb_rd  in  REG_ADDR_W; m_wb_reg_write  in  1
branch_taken  in  1  taken branch/jump resolved this cycle
pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en  out  1  stage register enables
if_id_flush, id_ex_flush, ex_m_flush  out  1  load bubble (all-zero control) into the register
fw1, fw2  out  2  operand select: 00 = ID/EX regfile data, 01 = M/WB write data, 10 = EX/M ALU result
mul_start  out  1  one-cycle pulse; the multiplier captures its operands
mul_busy  out  1  multiply stall in progress

Behaviour:
- Reset:
  - State RUN, counter 0.
  - While rst is high, all *_en=0, all flush=0, fw1/fw2=00, mul_start=0, mul_busy=0.
- enable low:
  - All *_en=0 and all flush=0.
  - FSM and counter hold.
  - fw outputs remain combinational.
- Forwarding (combinational), per operand:
  - 10 if ex_m_reg_write and ex_m_rd!=0 and ex_m_rd==id_ex_rsN.
  - Otherwise 01 if m_wb_reg_write and m_wb_rd!=0 and m_wb_rd==id_ex_rsN.
  - Otherwise 00.
  - EX/M beats M/WB; x0 is never forwarded.
- Load-use condition:
  - id_ex_mem_read and id_ex_rd!=0 and ((id_uses_rs1 and id_rs1==id_ex_rd) or (id_uses_rs2 and id_rs2==id_ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; other enables=1.
  - Lasts exactly one cycle; it clears naturally.
- Multiply FSM, states RUN, MUL_BUSY, MUL_DONE:
  - Stall in RUN: id_ex_is_mul and MUL_LAT>1 → mul_start=1.
    - Next state MUL_BUSY with cnt=MUL_LAT-3 if MUL_LAT>2, else MUL_DONE.
  - MUL_BUSY: stall; cnt==0 → MUL_DONE, else cnt-1.
  - MUL_DONE: no multiply stall; the multiply advances; next state RUN.
  - During stall: mul_busy=1, pc_en=if_id_en=id_ex_en=0, ex_m_flush=1, m_wb_en=1 (older instructions drain).
  - Total stall = MUL_LAT-1 cycles. MUL_LAT==1: the FSM never leaves RUN.
- Branch:
  - branch_taken → if_id_flush=1, id_ex_flush=1, ex_m_flush=1 iff FLUSH_DEPTH==3; all enables=1.
  - The FSM is forced to RUN (a younger multiply is squashed).
- Priority: rst > !enable > branch_taken > multiply stall > load-use. Lower-priority conditions are masked in that cycle.
- A load-use condition during a multiply stall is masked; it is re-evaluated after release.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles and flush_events, each CNT_W bits, cleared by rst.
  - stall_cycles increments every enabled cycle with pc_en=0.
  - flush_events increments on every branch flush.
  - Both saturate at all-ones.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - FSM state enum (RUN, MUL_BUSY, MUL_DONE);
  - fw select constants FW_RF=2'b00, FW_WB=2'b01, FW_EXM=2'b10.
- Sub-module hazard_fwd_sel: combinational forwarding comparator for one operand, instantiated twice (fw1, fw2).

Test Plan:
1. Reset: rst=1 for 2 cycles with arbitrary inputs → all *_en=0, flushes=0, fw=00; the cycle after release pc_en=1 and state RUN.
2. Forwarding: ex_m_rd=5, m_wb_rd=5, both reg_write=1, id_ex_rs1=5 → fw1=10. With ex_m_reg_write=0 → fw1=01. With rd=0 → fw1=00.
3. Load-use: id_ex_mem_read=1, id_ex_rd=7, id_rs2=7, id_uses_rs2=1 → exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then normal flow.
4. Multiply, MUL_LAT=4: id_ex_is_mul=1 → mul_start pulses in cycle 0, mul_busy=1 for 3 cycles with ex_m_flush=1, id_ex_en=1 on the 4th cycle. MUL_LAT=1 → no stall.
5. Branch during multiply (FLUSH_DEPTH=3): branch_taken=1 in the 2nd stall cycle → all three flushes=1, all enables=1, mul_busy=0 next cycle.
6. enable=0 mid-MUL_BUSY for 3 cycles → cnt and state frozen; the stall completes with the same remaining count after re-enable.
